// File: rtl/wb_port_arbiter.sv
// Write-port scheduler in front of the GPR file: per-producer result FIFOs
// drained by a round-robin arbiter onto two write ports, with a full-FIFO stall toward issue.
module wb_port_arbiter #(
  parameter int N_REQ = 4,
  parameter int DEPTH = 2,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  interlock,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ*AW-1:0]   req_rt,
  input  logic [N_REQ*DW-1:0]   req_data,
  output logic [N_REQ-1:0]      req_ready,
  output logic                  wp0_en,
  output logic [AW-1:0]         wp0_rt,
  output logic [DW-1:0]         wp0_data,
  output logic                  wp1_en,
  output logic [AW-1:0]         wp1_rt,
  output logic [DW-1:0]         wp1_data,
  output logic                  stall_out,
  output logic                  busy
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] rt_mem_q   [N_REQ][DEPTH];
  logic [AW-1:0] rt_mem_d   [N_REQ][DEPTH];
  logic [DW-1:0] data_mem_q [N_REQ][DEPTH];
  logic [DW-1:0] data_mem_d [N_REQ][DEPTH];
  logic [PW-1:0] wr_ptr_q   [N_REQ];
  logic [PW-1:0] wr_ptr_d   [N_REQ];
  logic [PW-1:0] rd_ptr_q   [N_REQ];
  logic [PW-1:0] rd_ptr_d   [N_REQ];
  logic [CW-1:0] count_q    [N_REQ];
  logic [CW-1:0] count_d    [N_REQ];
  logic [IW-1:0] rr_q;
  logic [IW-1:0] rr_d;

  logic [N_REQ-1:0] not_empty;
  logic [AW-1:0]    head_rt   [N_REQ];
  logic [DW-1:0]    head_data [N_REQ];
  logic [N_REQ-1:0] push;
  logic [N_REQ-1:0] pop;

  logic          g0;
  logic          g1;
  logic [IW-1:0] idx0;
  logic [IW-1:0] idx1;
  logic [IW-1:0] sidx;

  always_comb begin
    stall_out = 1'b0;
    busy      = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      not_empty[i] = (count_q[i] != '0);
      head_rt[i]   = rt_mem_q[i][rd_ptr_q[i]];
      head_data[i] = data_mem_q[i][rd_ptr_q[i]];
      req_ready[i] = !interlock && (count_q[i] < CW'(DEPTH));
      stall_out    = stall_out | (count_q[i] == CW'(DEPTH));
      busy         = busy | not_empty[i];
    end
  end

  // Round-robin scan from rr; a head matching port 0's index is skipped but keeps its place.
  always_comb begin
    g0   = 1'b0;
    g1   = 1'b0;
    idx0 = '0;
    idx1 = '0;
    sidx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sidx = IW'((int'(rr_q) + k) % N_REQ);
      if (not_empty[sidx]) begin
        if (!g0) begin
          g0   = 1'b1;
          idx0 = sidx;
        end else if (!g1 && (head_rt[sidx] != head_rt[idx0])) begin
          g1   = 1'b1;
          idx1 = sidx;
        end
      end
    end
  end

  always_comb begin
    wp0_en   = g0 && !interlock;
    wp1_en   = g1 && !interlock;
    wp0_rt   = wp0_en ? head_rt[idx0]   : '0;
    wp0_data = wp0_en ? head_data[idx0] : '0;
    wp1_rt   = wp1_en ? head_rt[idx1]   : '0;
    wp1_data = wp1_en ? head_data[idx1] : '0;
  end

  always_comb begin
    rt_mem_d   = rt_mem_q;
    data_mem_d = data_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rr_d       = rr_q;
    push       = '0;
    pop        = '0;
    for (int i = 0; i < N_REQ; i++) begin
      push[i] = req_valid[i] && req_ready[i];
      pop[i]  = (wp0_en && (idx0 == IW'(i))) || (wp1_en && (idx1 == IW'(i)));
      if (push[i]) begin
        rt_mem_d[i][wr_ptr_q[i]]   = req_rt[i*AW +: AW];
        data_mem_d[i][wr_ptr_q[i]] = req_data[i*DW +: DW];
        wr_ptr_d[i]                = wr_ptr_q[i] + PW'(1);
      end
      if (pop[i]) begin
        rd_ptr_d[i] = rd_ptr_q[i] + PW'(1);
      end
      count_d[i] = count_q[i] + CW'(push[i]) - CW'(pop[i]);
    end
    // The pointer moves past the last index granted in scan order.
    if (wp1_en) begin
      rr_d = (idx1 == IW'(N_REQ - 1)) ? '0 : idx1 + IW'(1);
    end else if (wp0_en) begin
      rr_d = (idx0 == IW'(N_REQ - 1)) ? '0 : idx0 + IW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_REQ; i++) begin
        for (int j = 0; j < DEPTH; j++) begin
          rt_mem_q[i][j]   <= '0;
          data_mem_q[i][j] <= '0;
        end
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
      rr_q <= '0;
    end else begin
      rt_mem_q   <= rt_mem_d;
      data_mem_q <= data_mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rr_q       <= rr_d;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios plus random traffic, checked every
// cycle against a queue-based model of the producer buffers and round-robin grants.
module tb_wb_port_arbiter;

  localparam int N     = 4;
  localparam int DEPTH = 2;
  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int W     = AW + DW;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            interlock = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*AW-1:0] req_rt = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_ready;
  logic            wp0_en, wp1_en;
  logic [AW-1:0]   wp0_rt, wp1_rt;
  logic [DW-1:0]   wp0_data, wp1_data;
  logic            stall_out, busy;

  wb_port_arbiter #(.N_REQ(N), .DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .interlock(interlock),
    .req_valid(req_valid), .req_rt(req_rt), .req_data(req_data), .req_ready(req_ready),
    .wp0_en(wp0_en), .wp0_rt(wp0_rt), .wp0_data(wp0_data),
    .wp1_en(wp1_en), .wp1_rt(wp1_rt), .wp1_data(wp1_data),
    .stall_out(stall_out), .busy(busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete, time %0t", $time);
    $fatal(1);
  end

  // scoreboard state: one expected queue per producer plus the round-robin pointer
  logic [W-1:0] exp_q [N][$];
  int           m_rr = 0;
  int           n_checks = 0;
  int           n_pass = 0;
  int           n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) exp_q[i].delete();
    m_rr = 0;
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    req_valid = '0;
    req_rt    = '0;
    req_data  = '0;
  endtask

  task automatic offer(input int i, input logic [AW-1:0] rt, input logic [DW-1:0] data);
    req_valid[i]          = 1'b1;
    req_rt[i*AW +: AW]    = rt;
    req_data[i*DW +: DW]  = data;
  endtask

  task automatic do_reset();
    clear_inputs();
    interlock = 1'b0;
    rst = 1'b1;
    model_clear();
    step();
    step();
    rst = 1'b0;
  endtask

  // monitor: derive the expected grants from the queue heads, compare, then advance the model
  bit           e_g0, e_g1, e_en0, e_en1, e_stall, e_busy;
  int           e_i0, e_i1;
  logic [W-1:0] h0, h1;
  logic [N-1:0] e_rdy;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        e_g0 = 0; e_g1 = 0; e_i0 = 0; e_i1 = 0; h0 = '0; h1 = '0;
        for (int k = 0; k < N; k++) begin
          int i;
          i = (m_rr + k) % N;
          if (exp_q[i].size() != 0) begin
            if (!e_g0) begin
              e_g0 = 1; e_i0 = i; h0 = exp_q[i][0];
            end else if (!e_g1 && exp_q[i][0][W-1:DW] != h0[W-1:DW]) begin
              e_g1 = 1; e_i1 = i; h1 = exp_q[i][0];
            end
          end
        end
        e_en0 = e_g0 && !interlock;
        e_en1 = e_g1 && !interlock;
        chk("wp0_en", wp0_en, e_en0);
        chk("wp0_rt", wp0_rt, e_en0 ? h0[W-1:DW] : '0);
        chk("wp0_data", wp0_data, e_en0 ? h0[DW-1:0] : '0);
        chk("wp1_en", wp1_en, e_en1);
        chk("wp1_rt", wp1_rt, e_en1 ? h1[W-1:DW] : '0);
        chk("wp1_data", wp1_data, e_en1 ? h1[DW-1:0] : '0);
        e_stall = 0; e_busy = 0;
        for (int i = 0; i < N; i++) begin
          e_rdy[i] = !interlock && (exp_q[i].size() < DEPTH);
          if (exp_q[i].size() == DEPTH) e_stall = 1;
          if (exp_q[i].size() != 0) e_busy = 1;
        end
        chk("req_ready", req_ready, e_rdy);
        chk("stall_out", stall_out, e_stall);
        chk("busy", busy, e_busy);
        chk("rr", dut.rr_q, m_rr);
        for (int i = 0; i < N; i++)
          if (req_valid[i] && e_rdy[i])
            exp_q[i].push_back({req_rt[i*AW +: AW], req_data[i*DW +: DW]});
        if (e_en0) void'(exp_q[e_i0].pop_front());
        if (e_en1) void'(exp_q[e_i1].pop_front());
        if (e_en1) m_rr = (e_i1 + 1) % N;
        else if (e_en0) m_rr = (e_i0 + 1) % N;
      end
    end
  end

  bit saw_stall, saw_drop;
  int total_left;
  logic [DW-1:0] dcount;

  initial begin
    // power-on reset
    @(posedge clk);
    #2;
    chk("reset_wp0_en", wp0_en, 1'b0);
    chk("reset_wp1_en", wp1_en, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_stall", stall_out, 1'b0);
    chk("reset_ready", req_ready, 4'hF);
    step();
    rst = 1'b0;

    // single write
    offer(0, 5'd3, 32'h12345678);
    step();
    clear_inputs();
    #1;
    chk("single_wp0_en", wp0_en, 1'b1);
    chk("single_wp0_rt", wp0_rt, 5'd3);
    chk("single_wp0_data", wp0_data, 32'h12345678);
    chk("single_wp1_en", wp1_en, 1'b0);
    step();
    chk("single_busy", busy, 1'b0);
    chk("single_rr", dut.rr_q, 1);

    // four producers, distinct indices
    do_reset();
    for (int i = 0; i < N; i++) offer(i, AW'(i + 1), 32'hA000_0000 + i);
    step();
    clear_inputs();
    #1;
    chk("four_c1_rt0", wp0_rt, 5'd1);
    chk("four_c1_rt1", wp1_rt, 5'd2);
    step();
    chk("four_c2_rt0", wp0_rt, 5'd3);
    chk("four_c2_rt1", wp1_rt, 5'd4);
    chk("four_c2_data1", wp1_data, 32'hA000_0003);
    step();
    chk("four_rr", dut.rr_q, 0);
    chk("four_busy", busy, 1'b0);

    // index conflict
    do_reset();
    offer(0, 5'd5, 32'hC0);
    offer(1, 5'd5, 32'hC1);
    offer(2, 5'd6, 32'hC2);
    step();
    clear_inputs();
    #1;
    chk("conf_c1_data0", wp0_data, 32'hC0);
    chk("conf_c1_rt1", wp1_rt, 5'd6);
    chk("conf_c1_data1", wp1_data, 32'hC2);
    step();
    chk("conf_c2_data0", wp0_data, 32'hC1);
    chk("conf_c2_en1", wp1_en, 1'b0);
    step();

    // saturation
    do_reset();
    saw_stall = 0; saw_drop = 0; dcount = 32'h100;
    for (int c = 0; c < 10; c++) begin
      for (int i = 0; i < N; i++) begin
        offer(i, AW'(8 + i), dcount);
        dcount = dcount + 1;
      end
      step();
      if (stall_out) saw_stall = 1;
      if (req_ready != 4'hF) saw_drop = 1;
    end
    clear_inputs();
    chk("sat_stall_seen", saw_stall, 1'b1);
    chk("sat_ready_drop_seen", saw_drop, 1'b1);
    repeat (8) step();
    chk("sat_drained", busy, 1'b0);

    // interlock freeze with two entries queued
    do_reset();
    offer(0, 5'd7, 32'hAAAA);
    offer(1, 5'd9, 32'hBBBB);
    step();
    clear_inputs();
    interlock = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("frz_wp0_en", wp0_en, 1'b0);
      chk("frz_ready", req_ready, 4'h0);
      chk("frz_busy", busy, 1'b1);
      step();
    end
    interlock = 1'b0;
    #1;
    chk("frz_rel_rt0", wp0_rt, 5'd7);
    chk("frz_rel_data1", wp1_data, 32'hBBBB);
    step();
    chk("frz_rel_busy", busy, 1'b0);

    // asynchronous reset in mid-cycle with three entries queued
    do_reset();
    offer(0, 5'd1, 32'h11);
    offer(1, 5'd2, 32'h22);
    offer(2, 5'd3, 32'h33);
    step();
    clear_inputs();
    #1;
    rst = 1'b1;
    #1;
    model_clear();
    chk("arst_wp0_en", wp0_en, 1'b0);
    chk("arst_wp0_data", wp0_data, '0);
    chk("arst_wp1_en", wp1_en, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_stall", stall_out, 1'b0);
    chk("arst_ready", req_ready, 4'hF);
    chk("arst_rr", dut.rr_q, 0);
    step();
    rst = 1'b0;
    offer(3, 5'd11, 32'hDEAD_BEEF);
    step();
    clear_inputs();
    #1;
    chk("arst_new_en", wp0_en, 1'b1);
    chk("arst_new_rt", wp0_rt, 5'd11);
    chk("arst_new_data", wp0_data, 32'hDEAD_BEEF);
    chk("arst_new_en1", wp1_en, 1'b0);
    step();
    chk("arst_new_busy", busy, 1'b0);

    // random traffic with conflicts and freezes
    for (int c = 0; c < 400; c++) begin
      interlock = ($urandom_range(0, 9) == 0);
      for (int i = 0; i < N; i++) begin
        req_valid[i]         = ($urandom_range(0, 2) != 0);
        req_rt[i*AW +: AW]   = AW'($urandom_range(0, 7));
        req_data[i*DW +: DW] = $urandom;
      end
      step();
    end
    clear_inputs();
    interlock = 1'b0;
    repeat (10) step();
    total_left = 0;
    for (int i = 0; i < N; i++) total_left += exp_q[i].size();
    chk("rand_model_drained", total_left, 0);
    chk("rand_busy", busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
